wb_cache: RTL
=============

WB_CACHE -- requirements
Module: wb_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width on both ports.
REQ-002 SHALL have parameter INDEX_W, default 6, meaning log2 of line count (direct-mapped).
REQ-003 SHALL have parameter WORDS, default 16, meaning 32-bit words per line, a power of 2 >= 2; LINE_W = 32*WORDS, OFF_W = log2(WORDS)+2, TAG_W = ADDR_W-INDEX_W-OFF_W.
REQ-004 SHALL have ports clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-005 SHALL have CPU read ports m_axi_araddr in ADDR_W; m_axi_arvalid in 1; m_axi_arready out 1; m_axi_rdata out 32; m_axi_rresp out 2; m_axi_rvalid out 1; m_axi_rready in 1.
REQ-006 SHALL have CPU write ports m_axi_awaddr in ADDR_W; m_axi_awvalid in 1; m_axi_awready out 1; m_axi_wdata in 32; m_axi_wstrb in 4; m_axi_wvalid in 1; m_axi_wready out 1; m_axi_bresp out 2; m_axi_bvalid out 1; m_axi_bready in 1.
REQ-007 SHALL have memory read ports s_axi_araddr out ADDR_W; s_axi_arvalid out 1; s_axi_arready in 1; s_axi_rdata in LINE_W; s_axi_rresp in 2; s_axi_rvalid in 1; s_axi_rready out 1.
REQ-008 SHALL have memory write ports s_axi_awaddr out ADDR_W; s_axi_awvalid out 1; s_axi_awready in 1; s_axi_wdata out LINE_W; s_axi_wvalid out 1; s_axi_wready in 1; s_axi_bresp in 2; s_axi_bvalid in 1; s_axi_bready out 1.
REQ-009 SHALL have control ports flush_req in 1 (write back all dirty lines); flush_done out 1 (one-cycle pulse); err out 1 (sticky memory-error flag).

Function
REQ-010 SHALL hold per line: valid, dirty, TAG_W tag, LINE_W data; address split {tag, index, word offset, 2'b00}.
REQ-011 SHALL use states IDLE, LOOKUP, WB_REQ, WB_RESP, FILL_REQ, FILL_DATA, RESP_R, RESP_W, FLUSH, ERROR.
REQ-012 In IDLE, arready SHALL be 1; awready and wready SHALL be 1 only when awvalid and wvalid are both 1 and arvalid is 0 (read priority); both accepted in the same cycle.
REQ-013 flush_req high in IDLE SHALL take priority over CPU requests, drop all readies, and enter FLUSH.
REQ-014 On acceptance, the block SHALL latch address, data and strobe and enter LOOKUP next cycle.
REQ-015 Read hit: m_axi_rvalid SHALL assert 2 cycles after the ar handshake with the addressed word, rresp=0; held until rready, then IDLE.
REQ-016 Write hit: strobed bytes SHALL be merged, line marked dirty, m_axi_bvalid asserted 2 cycles after handshake with bresp=0; held until bready, then IDLE.
REQ-017 Miss on invalid or clean line SHALL enter FILL_REQ: s_axi_araddr = {tag,index,OFF_W zeros}, arvalid held until arready; FILL_DATA: rready=1 until rvalid.
REQ-018 Miss on valid dirty line SHALL enter WB_REQ: awaddr = {old tag,index,0}, wdata = line; awvalid and wvalid each deassert independently on their ready; when both done, WB_RESP with bready=1 until bvalid, then FILL_REQ.
REQ-019 After fill, line SHALL be valid, clean, new tag; then the request SHALL complete as a hit (write additionally sets dirty), response 1 cycle after the fill beat.
REQ-020 FLUSH SHALL scan index 0 to 2^INDEX_W-1, one index per cycle if not dirty; each valid dirty line written back per REQ-018 and its dirty bit cleared; valid bits unchanged.
REQ-021 After the last index, flush_done SHALL pulse 1 cycle and state return to IDLE; flush_req is ignored outside IDLE.
REQ-022 s_axi_rresp[1]=1 or s_axi_bresp[1]=1 SHALL set err and enter ERROR; the line is not updated.
REQ-023 In ERROR, all ready/valid outputs SHALL be 0; only reset exits.
REQ-024 Only the addressed line SHALL change per request; other lines untouched.

Reset
REQ-025 On rst, the block SHALL enter IDLE immediately and clear all valid and dirty bits, err, flush_done and every valid/ready output; mid-transaction, outstanding memory transactions are abandoned and data arrays are not cleared.
REQ-026 The first clk edge after rst deasserts SHALL present m_axi_arready=1.

Verification
REQ-027 Reset, read 0x100 (WORDS=16,INDEX_W=6) -> s_axi_araddr=0x100; return line word4=0xDEADBEEF, read 0x110 -> rdata=0xDEADBEEF, no memory access.
REQ-028 Write 0x104 data 0x11223344 strb 4'b0011 onto line with 0xAAAAAAAA -> bvalid 2 cycles after handshake; readback 0xAAAA3344.
REQ-029 Dirty line index 4 tag A, then read 0x40000100 -> writeback awaddr=0x100 with merged line, then fill araddr=0x40000100; rdata correct.
REQ-030 Two dirty lines, flush_req -> exactly 2 writebacks, flush_done one pulse; refetch hits without writeback.
REQ-031 s_axi_rresp=2'b10 on fill -> err=1, readies 0; rst mid-writeback -> arready=1 after reset, earlier lines read as misses.
REQ-032 arvalid and awvalid/wvalid simultaneous -> read served first; awready stays 0 until return to IDLE.

Source files
------------

// File: rtl/wb_cache.sv
// Direct-mapped write-back cache: 32-bit AXI-style CPU port, full-line memory port,
// with whole-cache flush and a sticky memory-error stop state.
module wb_cache #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 6,
    parameter int WORDS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU read
    input  logic [ADDR_W-1:0]     m_axi_araddr,
    input  logic                  m_axi_arvalid,
    output logic                  m_axi_arready,
    output logic [31:0]           m_axi_rdata,
    output logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    // CPU write
    input  logic [ADDR_W-1:0]     m_axi_awaddr,
    input  logic                  m_axi_awvalid,
    output logic                  m_axi_awready,
    input  logic [31:0]           m_axi_wdata,
    input  logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_wvalid,
    output logic                  m_axi_wready,
    output logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bvalid,
    input  logic                  m_axi_bready,
    // memory read
    output logic [ADDR_W-1:0]     s_axi_araddr,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [32*WORDS-1:0]   s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    // memory write
    output logic [ADDR_W-1:0]     s_axi_awaddr,
    output logic                  s_axi_awvalid,
    input  logic                  s_axi_awready,
    output logic [32*WORDS-1:0]   s_axi_wdata,
    output logic                  s_axi_wvalid,
    input  logic                  s_axi_wready,
    input  logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_bvalid,
    output logic                  s_axi_bready,
    // control
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  err
);

    localparam int LINE_W = 32 * WORDS;
    localparam int WORD_W = $clog2(WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES  = 1 << INDEX_W;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOOKUP    = 4'd1;
    localparam logic [3:0] S_WB_REQ    = 4'd2;
    localparam logic [3:0] S_WB_RESP   = 4'd3;
    localparam logic [3:0] S_FILL_REQ  = 4'd4;
    localparam logic [3:0] S_FILL_DATA = 4'd5;
    localparam logic [3:0] S_RESP_R    = 4'd6;
    localparam logic [3:0] S_RESP_W    = 4'd7;
    localparam logic [3:0] S_FLUSH     = 4'd8;
    localparam logic [3:0] S_ERROR     = 4'd9;

    logic [3:0]         state;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] cur_idx;
    logic [WORD_W-1:0]  req_word;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wstrb;
    logic               req_write;
    logic               flushing;
    logic               aw_done;
    logic               w_done;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               flush_done_q;
    logic [LINES-1:0]   valid_bits;
    logic [LINES-1:0]   dirty_bits;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    logic [LINE_W-1:0]  cur_line;
    logic [LINE_W-1:0]  line_new;
    logic               line_we;
    logic               tag_we;
    logic               hit;
    logic               fill_ok;
    logic               aw_fire;
    logic               w_fire;

    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [WORD_W-1:0] w);
        return line[32*int'(w) +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [WORD_W-1:0] w,
                                                     input logic [31:0]       data,
                                                     input logic [3:0]        strb);
        logic [LINE_W-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[32*int'(w) + 8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign cur_line = data_mem[cur_idx];
    assign hit      = valid_bits[cur_idx] && (tag_mem[cur_idx] == req_tag);
    assign fill_ok  = (state == S_FILL_DATA) && s_axi_rvalid && !s_axi_rresp[1];
    assign aw_fire  = aw_done || (s_axi_awvalid && s_axi_awready);
    assign w_fire   = w_done  || (s_axi_wvalid && s_axi_wready);

    // CPU side: reads win over writes, flush wins over both.
    assign m_axi_arready = !rst && (state == S_IDLE) && !flush_req;
    assign m_axi_awready = !rst && (state == S_IDLE) && !flush_req && !m_axi_arvalid
                           && m_axi_awvalid && m_axi_wvalid;
    assign m_axi_wready  = m_axi_awready;
    assign m_axi_rdata   = rdata_q;
    assign m_axi_rresp   = 2'b00;
    assign m_axi_rvalid  = (state == S_RESP_R);
    assign m_axi_bresp   = 2'b00;
    assign m_axi_bvalid  = (state == S_RESP_W);

    assign s_axi_araddr  = {req_tag, cur_idx, {OFF_W{1'b0}}};
    assign s_axi_arvalid = (state == S_FILL_REQ);
    assign s_axi_rready  = (state == S_FILL_DATA);
    assign s_axi_awaddr  = {tag_mem[cur_idx], cur_idx, {OFF_W{1'b0}}};
    assign s_axi_wdata   = cur_line;
    assign s_axi_awvalid = (state == S_WB_REQ) && !aw_done;
    assign s_axi_wvalid  = (state == S_WB_REQ) && !w_done;
    assign s_axi_bready  = (state == S_WB_RESP);

    assign flush_done = flush_done_q;
    assign err        = err_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, m_axi_araddr[1:0], m_axi_awaddr[1:0],
                           s_axi_rresp[0], s_axi_bresp[0]};

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        line_we  = 1'b0;
        tag_we   = 1'b0;
        line_new = cur_line;
        if (state == S_LOOKUP && hit && req_write) begin
            line_we  = 1'b1;
            line_new = merge_word(cur_line, req_word, req_wdata, req_wstrb);
        end else if (fill_ok) begin
            line_we  = 1'b1;
            tag_we   = 1'b1;
            line_new = req_write ? merge_word(s_axi_rdata, req_word, req_wdata, req_wstrb)
                                 : s_axi_rdata;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (line_we) data_mem[cur_idx] <= line_new;
        if (tag_we)  tag_mem[cur_idx]  <= req_tag;
    end

    // NOTE: all state registers use non-blocking assignment so every update sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            req_tag      <= '0;
            cur_idx      <= '0;
            req_word     <= '0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            req_write    <= 1'b0;
            flushing     <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
            valid_bits   <= '0;
            dirty_bits   <= '0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        flushing <= 1'b1;
                        cur_idx  <= '0;
                        state    <= S_FLUSH;
                    end else if (m_axi_arvalid) begin
                        req_tag   <= m_axi_araddr[ADDR_W-1 -: TAG_W];
                        cur_idx   <= m_axi_araddr[OFF_W +: INDEX_W];
                        req_word  <= m_axi_araddr[2 +: WORD_W];
                        req_write <= 1'b0;
                        flushing  <= 1'b0;
                        state     <= S_LOOKUP;
                    end else if (m_axi_awvalid && m_axi_wvalid) begin
                        req_tag   <= m_axi_awaddr[ADDR_W-1 -: TAG_W];
                        cur_idx   <= m_axi_awaddr[OFF_W +: INDEX_W];
                        req_word  <= m_axi_awaddr[2 +: WORD_W];
                        req_wdata <= m_axi_wdata;
                        req_wstrb <= m_axi_wstrb;
                        req_write <= 1'b1;
                        flushing  <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (req_write) begin
                            dirty_bits[cur_idx] <= 1'b1;
                            state               <= S_RESP_W;
                        end else begin
                            rdata_q <= get_word(cur_line, req_word);
                            state   <= S_RESP_R;
                        end
                    end else if (valid_bits[cur_idx] && dirty_bits[cur_idx]) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WB_REQ;
                    end else begin
                        state <= S_FILL_REQ;
                    end
                end
                S_WB_REQ: begin
                    // Address and data channels may complete in different cycles.
                    if (s_axi_awvalid && s_axi_awready) aw_done <= 1'b1;
                    if (s_axi_wvalid && s_axi_wready)   w_done  <= 1'b1;
                    if (aw_fire && w_fire)              state   <= S_WB_RESP;
                end
                S_WB_RESP: begin
                    if (s_axi_bvalid) begin
                        if (s_axi_bresp[1]) begin
                            err_q <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            dirty_bits[cur_idx] <= 1'b0;
                            state <= flushing ? S_FLUSH : S_FILL_REQ;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (s_axi_arready) state <= S_FILL_DATA;
                end
                S_FILL_DATA: begin
                    if (s_axi_rvalid) begin
                        if (s_axi_rresp[1]) begin
                            err_q <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            valid_bits[cur_idx] <= 1'b1;
                            dirty_bits[cur_idx] <= req_write;
                            rdata_q             <= get_word(s_axi_rdata, req_word);
                            state               <= req_write ? S_RESP_W : S_RESP_R;
                        end
                    end
                end
                S_RESP_R: begin
                    if (m_axi_rready) state <= S_IDLE;
                end
                S_RESP_W: begin
                    if (m_axi_bready) state <= S_IDLE;
                end
                S_FLUSH: begin
                    // A written-back index is revisited once; it is then clean and the scan moves on.
                    if (valid_bits[cur_idx] && dirty_bits[cur_idx]) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WB_REQ;
                    end else if (&cur_idx) begin
                        flush_done_q <= 1'b1;
                        flushing     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        cur_idx <= cur_idx + INDEX_W'(1);
                    end
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
